// File: rtl/ysyx_22041412_axi_pkg.sv
// Shared definitions for the simplified read/write request bus.
//   bust_e     : beat size codes (bytes per beat = 2^code)
//   r_state_e  : read channel FSM states
//   w_state_e  : write channel FSM states
//   eff_size() : clamps a raw 3-bit size code to the 8-byte maximum
package ysyx_22041412_axi_pkg;

  typedef enum logic [2:0] {
    BUST_1 = 3'd0,
    BUST_2 = 3'd1,
    BUST_4 = 3'd2,
    BUST_8 = 3'd3
  } bust_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_BEAT = 2'd2
  } r_state_e;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_BUSY = 1'b1
  } w_state_e;

  // Codes above 8 bytes have no meaning on a 64-bit bus; treat them as 8 bytes.
  function automatic logic [1:0] eff_size(input logic [2:0] size);
    if (size > 3'(BUST_8)) return 2'(BUST_8);
    return size[1:0];
  endfunction

endpackage

// File: rtl/ysyx_22041412_strb_gen.sv
// Byte-lane strobe generator for a 64-bit beat.
//   size   : in,  beat size code (>=4 behaves as 8 bytes)
//   offset : in,  byte offset of the beat within the word (addr[2:0])
//   strobe : out, one bit per byte lane; lanes past 7 are dropped, so a
//            misaligned beat is truncated at the word boundary
module ysyx_22041412_strb_gen
  import ysyx_22041412_axi_pkg::*;
(
  input  logic [2:0] size,
  input  logic [2:0] offset,
  output logic [7:0] strobe
);

  logic [15:0] base;
  logic [15:0] shifted;

  always_comb begin
    base = 16'h00ff;
    case (eff_size(size))
      2'd0:    base = 16'h0001;
      2'd1:    base = 16'h0003;
      2'd2:    base = 16'h000f;
      default: base = 16'h00ff;
    endcase
  end

  // Shift in a 16-bit field so lanes that fall off the top are simply cut.
  assign shifted = base << offset;
  assign strobe  = shifted[7:0];

endmodule

// File: rtl/ysyx_22041412_rw_mem_responder.sv
// Burst memory responder for the simplified read/write request bus.
// Independent read and write FSMs over a 1R1W word array.
//   clk, rst                      : clock, async active-high reset
//   r_valid_i/r_addr_i/r_size_i/r_len_i : read burst request (held for burst)
//   r_ready_o/data_read_o/r_last_i : registered read beat, data, final beat
//   w_valid_i/w_addr_i/w_size_i/w_len_i : write burst request / beat valid
//   rw_w_data_i                   : lane-aligned write beat data
//   w_ready_o/w_last_i            : beat accepted this cycle / it is the final one
module ysyx_22041412_rw_mem_responder
  import ysyx_22041412_axi_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 32,
  parameter int DEPTH      = 4096,
  parameter int RD_LATENCY = 1
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              r_valid_i,
  input  logic [ADDR_W-1:0] r_addr_i,
  input  logic [2:0]        r_size_i,
  input  logic [7:0]        r_len_i,
  output logic              r_ready_o,
  output logic [DATA_W-1:0] data_read_o,
  output logic              r_last_i,
  input  logic              w_valid_i,
  input  logic [ADDR_W-1:0] w_addr_i,
  input  logic [2:0]        w_size_i,
  input  logic [7:0]        w_len_i,
  input  logic [DATA_W-1:0] rw_w_data_i,
  output logic              w_ready_o,
  output logic              w_last_i
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(RD_LATENCY + 1);

  logic [DATA_W-1:0] mem [DEPTH];

  // ---------------------------------------------------------------- read
  r_state_e          r_state, r_next;
  logic [ADDR_W-1:0] r_addr_q;
  logic [7:0]        r_len_q, r_cnt_q;
  logic [2:0]        r_size_q;
  logic [CNT_W-1:0]  r_lat_q;

  logic              r_accept, r_beat_go;
  logic [ADDR_W-1:0] rb_addr;
  logic [7:0]        rb_len, rb_cnt;
  logic [2:0]        rb_size;

  // Descriptor of the beat that would be loaded at this edge. In R_IDLE the
  // request is not latched yet, so take it straight from the inputs.
  assign rb_addr = r_accept ? r_addr_i : r_addr_q;
  assign rb_len  = r_accept ? r_len_i  : r_len_q;
  assign rb_size = r_accept ? r_size_i : r_size_q;
  assign rb_cnt  = r_accept ? 8'd0     : r_cnt_q;

  // Beat outputs are registered, so a beat is loaded on the edge that enters
  // (or stays in) R_BEAT. That is why R_WAIT leaves when the counter reaches
  // 1 rather than 0: the beat register adds the final cycle of latency.
  always_comb begin
    r_next    = r_state;
    r_accept  = 1'b0;
    r_beat_go = 1'b0;
    case (r_state)
      R_IDLE: if (r_valid_i) begin
        r_accept = 1'b1;
        if (RD_LATENCY == 1) begin
          r_next    = R_BEAT;
          r_beat_go = 1'b1;
        end else begin
          r_next = R_WAIT;
        end
      end
      R_WAIT: begin
        if (!r_valid_i) begin
          r_next = R_IDLE;
        end else if (r_lat_q == CNT_W'(1)) begin
          r_next    = R_BEAT;
          r_beat_go = 1'b1;
        end
      end
      R_BEAT: begin
        // r_last_i marks the beat on the bus this cycle; never chain a new
        // request onto it.
        if (!r_valid_i || r_last_i) r_next = R_IDLE;
        else                        r_beat_go = 1'b1;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= R_IDLE;
      r_addr_q    <= '0;
      r_len_q     <= '0;
      r_size_q    <= '0;
      r_cnt_q     <= '0;
      r_lat_q     <= '0;
      r_ready_o   <= 1'b0;
      r_last_i    <= 1'b0;
      data_read_o <= '0;
    end else begin
      r_state <= r_next;
      if (r_accept) begin
        r_len_q  <= r_len_i;
        r_size_q <= r_size_i;
        r_lat_q  <= CNT_W'(RD_LATENCY - 1);
      end else if (r_state == R_WAIT) begin
        r_lat_q <= r_lat_q - 1'b1;
      end
      if (r_beat_go) begin
        r_addr_q <= rb_addr + (ADDR_W'(1) << eff_size(rb_size));
        r_cnt_q  <= rb_cnt + 8'd1;
      end else if (r_accept) begin
        r_addr_q <= r_addr_i;
        r_cnt_q  <= 8'd0;
      end
      r_ready_o   <= r_beat_go;
      r_last_i    <= r_beat_go & (rb_cnt == rb_len);
      // Reads sample the array before this edge's write lands: old data wins.
      data_read_o <= r_beat_go ? mem[rb_addr[3 +: IDX_W]] : '0;
    end
  end

  // --------------------------------------------------------------- write
  w_state_e          w_state, w_next;
  logic [ADDR_W-1:0] w_addr_q;
  logic [7:0]        w_len_q, w_cnt_q;
  logic [2:0]        w_size_q;
  logic [7:0]        strobe;

  ysyx_22041412_strb_gen u_strb (
    .size   (w_size_q),
    .offset (w_addr_q[2:0]),
    .strobe (strobe)
  );

  assign w_ready_o = (w_state == W_BUSY) & w_valid_i;
  assign w_last_i  = w_ready_o & (w_cnt_q == w_len_q);

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (w_valid_i) w_next = W_BUSY;
      W_BUSY:  if (!w_valid_i || w_last_i) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state  <= W_IDLE;
      w_addr_q <= '0;
      w_len_q  <= '0;
      w_size_q <= '0;
      w_cnt_q  <= '0;
    end else begin
      w_state <= w_next;
      if (w_state == W_IDLE && w_valid_i) begin
        w_addr_q <= w_addr_i;
        w_len_q  <= w_len_i;
        w_size_q <= w_size_i;
        w_cnt_q  <= 8'd0;
      end else if (w_ready_o) begin
        w_addr_q <= w_addr_q + (ADDR_W'(1) << eff_size(w_size_q));
        w_cnt_q  <= w_cnt_q + 8'd1;
      end
    end
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_ready_o) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (strobe[b]) mem[w_addr_q[3 +: IDX_W]][b*8 +: 8] <= rw_w_data_i[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22041412_rw_mem_responder.sv
module tb_ysyx_22041412_rw_mem_responder;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main instance (RD_LATENCY=1) read port
  logic        r_valid = 1'b0;
  logic [31:0] r_addr = '0;
  logic [2:0]  r_size = '0;
  logic [7:0]  r_len = '0;
  logic        r_ready, r_last;
  logic [63:0] r_data;
  // second instance (RD_LATENCY=3) read port
  logic        l3_r_valid = 1'b0;
  logic [31:0] l3_r_addr = '0;
  logic [2:0]  l3_r_size = '0;
  logic [7:0]  l3_r_len = '0;
  logic        l3_r_ready, l3_r_last;
  logic [63:0] l3_r_data;
  // write port shared by both instances so their arrays stay identical
  logic        w_valid = 1'b0;
  logic [31:0] w_addr = '0;
  logic [2:0]  w_size = '0;
  logic [7:0]  w_len = '0;
  logic [63:0] w_data = '0;
  logic        w_ready, w_last, l3_w_ready, l3_w_last;

  ysyx_22041412_rw_mem_responder #(.DATA_W(64), .ADDR_W(32), .DEPTH(DEPTH), .RD_LATENCY(1)) u_dut (
    .clk(clk), .rst(rst),
    .r_valid_i(r_valid), .r_addr_i(r_addr), .r_size_i(r_size), .r_len_i(r_len),
    .r_ready_o(r_ready), .data_read_o(r_data), .r_last_i(r_last),
    .w_valid_i(w_valid), .w_addr_i(w_addr), .w_size_i(w_size), .w_len_i(w_len),
    .rw_w_data_i(w_data), .w_ready_o(w_ready), .w_last_i(w_last)
  );

  ysyx_22041412_rw_mem_responder #(.DATA_W(64), .ADDR_W(32), .DEPTH(DEPTH), .RD_LATENCY(3)) u_dut_l3 (
    .clk(clk), .rst(rst),
    .r_valid_i(l3_r_valid), .r_addr_i(l3_r_addr), .r_size_i(l3_r_size), .r_len_i(l3_r_len),
    .r_ready_o(l3_r_ready), .data_read_o(l3_r_data), .r_last_i(l3_r_last),
    .w_valid_i(w_valid), .w_addr_i(w_addr), .w_size_i(w_size), .w_len_i(w_len),
    .rw_w_data_i(w_data), .w_ready_o(l3_w_ready), .w_last_i(l3_w_last)
  );

  typedef struct {
    logic [63:0] data;
    logic        last;
    int          cyc;
  } beat_t;

  logic [63:0] model [DEPTH];
  beat_t       sb [$];
  int          checks = 0;
  int          errors = 0;

  logic        sel_l3 = 1'b0;
  logic        mon_ready, mon_last;
  logic [63:0] mon_data;
  assign mon_ready = sel_l3 ? l3_r_ready : r_ready;
  assign mon_last  = sel_l3 ? l3_r_last  : r_last;
  assign mon_data  = sel_l3 ? l3_r_data  : r_data;

  function automatic int eff(input logic [2:0] s);
    return (s > 3) ? 3 : int'(s);
  endfunction

  // Byte-wise model of a strobed write; bytes past lane 7 are dropped.
  function automatic void model_write(input logic [31:0] a, input logic [2:0] s, input logic [63:0] d);
    int off, n;
    off = int'(a[2:0]);
    n   = 1 << eff(s);
    for (int b = off; b < off + n && b < 8; b++) model[a[6:3]][b*8 +: 8] = d[b*8 +: 8];
  endfunction

  // Write burst: beat k carries d0 + k*dstep. abort_after >= 0 sends only
  // that many beats, then drops w_valid.
  task automatic do_write(input logic [31:0] a, input logic [7:0] len, input logic [2:0] s,
                          input logic [63:0] d0, input logic [63:0] dstep,
                          input int abort_after, input string name);
    logic [31:0] ad;
    logic [63:0] d;
    int nb;
    nb = (abort_after >= 0) ? abort_after : int'(len) + 1;
    @(negedge clk);
    w_valid = 1'b1; w_addr = a; w_len = len; w_size = s; w_data = d0;
    #1;
    checks++;
    if (w_ready !== 1'b0 || l3_w_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_ready: w_ready=%b/%b expected 0", name, w_ready, l3_w_ready);
    end
    ad = a;
    for (int k = 0; k < nb; k++) begin
      @(negedge clk);
      d = d0 + 64'(k) * dstep;
      w_data = d;
      #1;
      checks++;
      if (w_ready !== 1'b1 || l3_w_ready !== 1'b1 || w_last !== (k == int'(len)) || l3_w_last !== (k == int'(len))) begin
        errors++;
        $display("FAIL %s beat%0d: w_ready=%b/%b w_last=%b/%b expected ready=1 last=%b",
                 name, k, w_ready, l3_w_ready, w_last, l3_w_last, (k == int'(len)));
      end
      model_write(ad, s, d);
      ad = ad + (32'(1) << eff(s));
    end
    @(negedge clk);
    w_valid = 1'b0;
  endtask

  // Read burst with scoreboard. cancel_at >= 0 drops r_valid in the cycle
  // beat cancel_at is observed; no later beat may appear.
  task automatic do_read(input bit l3, input logic [31:0] a, input logic [7:0] len, input logic [2:0] s,
                         input int cancel_at, input string name);
    int lat, nexp, seen, c0;
    logic [31:0] ad;
    beat_t b;
    lat  = l3 ? 3 : 1;
    nexp = (cancel_at >= 0) ? cancel_at + 1 : int'(len) + 1;
    @(negedge clk);
    sel_l3 = l3;
    c0 = cyc;
    if (l3) begin
      l3_r_valid = 1'b1; l3_r_addr = a; l3_r_len = len; l3_r_size = s;
    end else begin
      r_valid = 1'b1; r_addr = a; r_len = len; r_size = s;
    end
    ad = a;
    for (int k = 0; k < nexp; k++) begin
      b.data = model[ad[6:3]];
      b.last = (k == int'(len));
      b.cyc  = c0 + lat + k;
      sb.push_back(b);
      ad = ad + (32'(1) << eff(s));
    end
    seen = 0;
    while (cyc < c0 + lat + int'(len) + 4) begin
      @(negedge clk);
      checks++;
      if (mon_ready === 1'b1) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL %s extra_beat: cycle %0d data=%h, expected no beat", name, cyc - c0, mon_data);
        end else begin
          b = sb.pop_front();
          if (mon_data !== b.data || mon_last !== b.last || cyc != b.cyc) begin
            errors++;
            $display("FAIL %s beat%0d: data=%h last=%b at T+%0d, expected data=%h last=%b at T+%0d",
                     name, seen, mon_data, mon_last, cyc - c0, b.data, b.last, b.cyc - c0);
          end
        end
        seen++;
        if (seen == nexp) begin
          r_valid = 1'b0; l3_r_valid = 1'b0;
        end
      end else if (mon_ready !== 1'b0 || mon_data !== 64'd0 || mon_last !== 1'b0) begin
        errors++;
        $display("FAIL %s idle_outputs: T+%0d ready=%b data=%h last=%b, expected all 0",
                 name, cyc - c0, mon_ready, mon_data, mon_last);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s missing_beats: %0d outstanding, expected 0", name, sb.size());
      sb.delete();
    end
    r_valid = 1'b0; l3_r_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if (r_ready !== 1'b0 || r_data !== 64'd0 || r_last !== 1'b0 || w_ready !== 1'b0 || w_last !== 1'b0 ||
        l3_r_ready !== 1'b0 || l3_r_data !== 64'd0 || l3_r_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: r_ready=%b data=%h r_last=%b w_ready=%b w_last=%b l3_ready=%b, expected all 0",
               r_ready, r_data, r_last, w_ready, w_last, l3_r_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_init;
    do_write(32'h8000_0000, 8'd15, 3'd3, 64'h0123_4567_89ab_cdef, 64'h1111_1111_1111_1111, -1, "init_fill");
  endtask

  task automatic test_write_read;
    do_write(32'h8000_0000, 8'd3, 3'd3, 64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111, -1, "wr_burst");
    do_read(1'b0, 32'h8000_0000, 8'd3, 3'd3, -1, "rd_burst");
  endtask

  task automatic test_partial;
    do_write(32'h8000_0013, 8'd0, 3'd1, 64'hffff_ffaa_bbff_ffff, 64'd0, -1, "wr_half_lane3");
    do_write(32'h8000_0026, 8'd0, 3'd2, 64'ha5a5_a5a5_a5a5_a5a5, 64'd0, -1, "wr_trunc");
    do_write(32'h8000_0030, 8'd0, 3'd5, 64'hdead_beef_cafe_f00d, 64'd0, -1, "wr_size5");
    do_read(1'b0, 32'h8000_0010, 8'd4, 3'd3, -1, "rd_partial");
    do_read(1'b0, 32'h8000_0000, 8'd3, 3'd2, -1, "rd_narrow");
  endtask

  task automatic test_write_abort;
    do_write(32'h8000_0040, 8'd3, 3'd3, 64'h7777_0000_0000_0001, 64'd1, 2, "wr_abort");
    do_read(1'b0, 32'h8000_0040, 8'd3, 3'd3, -1, "rd_after_abort");
  endtask

  task automatic test_cancel;
    do_read(1'b0, 32'h8000_0000, 8'd7, 3'd3, 2, "rd_cancel");
    do_read(1'b0, 32'h8000_0040, 8'd1, 3'd3, -1, "rd_after_cancel");
  endtask

  task automatic test_wrap;
    do_read(1'b0, 32'h8000_0078, 8'd1, 3'd3, -1, "rd_wrap");
  endtask

  task automatic test_reset_mid;
    int  n;
    bit  hit;
    @(negedge clk);
    sel_l3 = 1'b0;
    r_valid = 1'b1; r_addr = 32'h8000_0000; r_len = 8'd3; r_size = 3'd3;
    n = 0; hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      if (r_ready === 1'b1) begin
        if (n == 2) hit = 1'b1;
        n++;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reset_mid_beat2: saw %0d beats, expected beat 2 before reset", n);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (r_ready !== 1'b0 || r_data !== 64'd0 || r_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_clear: ready=%b data=%h last=%b, expected all 0", r_ready, r_data, r_last);
    end
    @(negedge clk);
    r_valid = 1'b0;
    rst = 1'b0;
    do_read(1'b0, 32'h8000_0000, 8'd0, 3'd3, -1, "rd_after_reset");
  endtask

  task automatic test_latency;
    do_read(1'b1, 32'h8000_0008, 8'd2, 3'd3, -1, "rd_lat3");
  endtask

  task automatic test_concurrency;
    fork
      do_write(32'h8000_0028, 8'd0, 3'd3, 64'h5555_6666_7777_8888, 64'd0, -1, "wr_conc");
      do_read(1'b0, 32'h8000_0028, 8'd0, 3'd3, -1, "rd_conc_old");
    join
    do_read(1'b0, 32'h8000_0028, 8'd0, 3'd3, -1, "rd_conc_new");
    do_read(1'b1, 32'h8000_0028, 8'd0, 3'd3, -1, "rd_conc_new_lat3");
  endtask

  initial begin
    test_reset();
    test_init();
    test_write_read();
    test_partial();
    test_write_abort();
    test_cancel();
    test_wrap();
    test_reset_mid();
    test_latency();
    test_concurrency();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
